cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Parametrised on-chip trace capture unit; successor to the bench-level per-cycle `$display` debug of CPU_Top.
- Sits beside CPU_Top and samples one record per retired instruction: PC, IR, ALU result and the MemWrite flag.
- Captures into a circular buffer, stops a programmable number of records after a PC-match trigger, then drains oldest-first over a valid/ready port.
- Gives synthesisable post-mortem visibility without simulator printing.

Parameters:
- DATA_WIDTH, 32, width of the IR and ALU fields.
- ADDR_WIDTH, 8, width of the PC and trigger fields.
- DEPTH, 16, number of records held; must be a power of two, at least 2.
- PTR_WIDTH, 4, log2(DEPTH); width of the pointers and of post_count.
- TS_WIDTH, 16, timestamp width; used only with TRACE_TIMESTAMP_EN.

Ports:
- clk  input  1  rising-edge clock, shared with CPU_Top.
- reset  input  1  asynchronous, active-low reset.
- arm  input  1  pulse: clear the buffer and start capture.
- trig_pc  input  ADDR_WIDTH  PC value that fires the trigger.
- post_count  input  PTR_WIDTH  records to capture after the trigger record; sampled on the trigger cycle.
- valid_in  input  1  retire strobe: the current record is valid.
- pc_in  input  ADDR_WIDTH  PC of the retiring instruction.
- ir_in  input  DATA_WIDTH  IR of the retiring instruction.
- alu_in  input  DATA_WIDTH  ALU result.
- we_in  input  1  MemWrite of the retiring instruction.
- rd_ready  input  1  consumer accepts the head record.
- rd_valid  output  1  head record is available.
- rd_pc  output  ADDR_WIDTH  head record PC.
- rd_ir  output  DATA_WIDTH  head record IR.
- rd_alu  output  DATA_WIDTH  head record ALU result.
- rd_we  output  1  head record MemWrite.
- state  output  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- level  output  PTR_WIDTH+1  number of records held, 0..DEPTH.
- overflow  output  1  sticky: at least one record was overwritten since arm.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; read/write pointers, level, post counter and overflow all zero.
  - rd_valid=0; rd_pc/rd_ir/rd_alu/rd_we=0.
  - Storage contents need not be cleared.
  - Reset asserted mid-capture or mid-drain aborts immediately; no partial pop.
- All other state changes occur on the rising clk edge.
- arm has the highest priority in every state.
  - It clears the pointers, level and overflow and enters ARMED.
  - valid_in and the trigger are ignored on the arm cycle.
- IDLE:
  - valid_in is ignored.
  - rd_valid=0.
- ARMED:
  - Each valid_in writes {pc,ir,alu,we} at the write pointer, which then increments and wraps at DEPTH.
  - If level==DEPTH, the write also advances the read pointer (oldest record overwritten), level stays DEPTH, and overflow is set.
  - Trigger fires when valid_in=1 and pc_in==trig_pc; the trigger record itself is captured.
  - post_count is latched on the trigger cycle, clamped to DEPTH-1 so the trigger record always survives.
  - Latched post_count==0: go to DONE. Otherwise go to POST with the counter loaded.
- POST:
  - Capture rules are the same as ARMED; the trigger is not re-evaluated.
  - Each captured record decrements the counter; the capture that brings it to 0 moves to DONE on the same edge.
- DONE:
  - valid_in is ignored.
  - rd_valid = (level!=0). rd_* are show-ahead and combinational from the read pointer.
  - Pop when rd_valid and rd_ready: read pointer increments with wrap, level decrements.
  - The pop that brings level to 0 moves to IDLE.
  - rd_ready while rd_valid=0 has no effect.
- rd_* outputs are 0 whenever rd_valid=0.
- The PC comparison is an exact full-width equality.
- No record is lost or duplicated across pointer wrap.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A TS_WIDTH free-running cycle counter runs from reset (reset value 0) and wraps modulo 2^TS_WIDTH.
  - Each captured record also stores the counter value.
  - Extra output port rd_ts (TS_WIDTH) follows the same show-ahead and zeroing rules as rd_pc.
- Undefined: no counter, no rd_ts port, no timestamp storage.

Test Plan:
- Reset, then arm. Five valid_in with PC 00..04, trig_pc=03, post_count=1 -> state reaches DONE after PC 04; level=5; drain yields PC 00,01,02,03,04 in order; overflow=0; state=IDLE after the 5th pop.
- DEPTH=16, trig_pc=FF. 20 records with PC 00..13, then PC FF with post_count=0 -> level=16, overflow=1, drain yields PC 05..13 then FF.
- post_count=15 with DEPTH=16 and the trigger at PC 10 -> clamp to 15: trigger record is the head; 15 following records; level=16.
- In DONE with level=4, hold rd_ready=0 for 3 cycles -> rd_pc is stable and no pop occurs. Pulse arm -> state=ARMED, level=0, rd_valid=0.
- Assert reset low mid-POST for half a clock -> all outputs 0 immediately. After release: state IDLE; valid_in is ignored until arm.
- With TRACE_TIMESTAMP_EN: arm at cycle 10; valid_in on cycles 12, 13, 17; trigger at 17 with post_count=0 -> rd_ts reads 12, 13, 17.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: on-chip retire trace capture for CPU_Top.
// Records {pc, ir, alu, we} per retired instruction into a circular buffer.
// After a PC-match trigger it captures post_count more records, then drains
// the buffer oldest-first over a show-ahead valid/ready port.
// Optional build macro TRACE_TIMESTAMP_EN adds a free-running cycle stamp
// per record and the rd_ts output.
module cpu_trace_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_WIDTH  = 4,
  parameter int unsigned TS_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] trig_pc,
  input  logic [PTR_WIDTH-1:0]  post_count,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] ir_in,
  input  logic [DATA_WIDTH-1:0] alu_in,
  input  logic                  we_in,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_pc,
  output logic [DATA_WIDTH-1:0] rd_ir,
  output logic [DATA_WIDTH-1:0] rd_alu,
  output logic                  rd_we,
  output logic [1:0]            state,
  output logic [PTR_WIDTH:0]    level,
  output logic                  overflow
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]   rd_ts
`endif
);

  // Reject configurations where the pointers cannot address the buffer exactly.
  if (DEPTH < 2 || DEPTH != (1 << PTR_WIDTH) || TS_WIDTH < 1) begin : g_param_chk
    $error("cpu_trace_buffer: DEPTH must equal 2**PTR_WIDTH and be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   ts;
`endif
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] alu;
    logic                  we;
  } rec_t;

  localparam logic [PTR_WIDTH:0] LVL_FULL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] MAX_POST = (PTR_WIDTH+1)'(DEPTH - 1);

  state_t               st_q;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr, post_cnt;
  logic [PTR_WIDTH:0]   lvl;
  logic                 ovf;
  rec_t                 mem [DEPTH];

  rec_t                 rec_in, head;
  logic                 capture, trig_hit, full, pop;
  logic [PTR_WIDTH-1:0] post_lim;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]  ts_q;

  // Free-running cycle stamp; wraps naturally at 2^TS_WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end
`endif

  // Capture/trigger/pop qualifiers; arm suppresses everything else on its cycle.
  always_comb begin
    rec_in     = '0;
`ifdef TRACE_TIMESTAMP_EN
    rec_in.ts  = ts_q;
`endif
    rec_in.pc  = pc_in;
    rec_in.ir  = ir_in;
    rec_in.alu = alu_in;
    rec_in.we  = we_in;
    capture    = valid_in && !arm && (st_q == S_ARMED || st_q == S_POST);
    trig_hit   = capture && (st_q == S_ARMED) && (pc_in == trig_pc);
    full       = (lvl == LVL_FULL);
    rd_valid   = (st_q == S_DONE) && (lvl != '0);
    pop        = rd_valid && rd_ready && !arm;
    // Clamp keeps the trigger record from being overwritten by its own tail.
    post_lim   = ({1'b0, post_count} > MAX_POST) ? MAX_POST[PTR_WIDTH-1:0] : post_count;
  end

  // Record storage; contents are don't-care until written after arm.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= rec_in;
  end

  // Pointer, level, overflow and capture-state sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      post_cnt <= '0;
      ovf      <= 1'b0;
    end else if (arm) begin
      st_q     <= S_ARMED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      post_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) begin
          // Oldest record is overwritten: head moves with the tail.
          rd_ptr <= rd_ptr + 1'b1;
          ovf    <= 1'b1;
        end else begin
          lvl <= lvl + 1'b1;
        end
      end
      unique case (st_q)
        S_ARMED: if (trig_hit) begin
          if (post_lim == '0) st_q <= S_DONE;
          else begin
            st_q     <= S_POST;
            post_cnt <= post_lim;
          end
        end
        S_POST: if (capture) begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == PTR_WIDTH'(1)) st_q <= S_DONE;
        end
        S_DONE: if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          lvl    <= lvl - 1'b1;
          if (lvl == (PTR_WIDTH+1)'(1)) st_q <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Show-ahead head record, forced to zero while nothing is presented.
  always_comb begin
    head = rd_valid ? mem[rd_ptr] : '0;
  end

  assign rd_pc    = head.pc;
  assign rd_ir    = head.ir;
  assign rd_alu   = head.alu;
  assign rd_we    = head.we;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_ts    = head.ts;
`endif
  assign state    = st_q;
  assign level    = lvl;
  assign overflow = ovf;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: stimulus pushes expected drain records
// into a queue, a negedge monitor pops and compares on every accepted record.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic [7:0]  trig_pc = '0;
  logic [3:0]  post_count = '0;
  logic        valid_in = 1'b0;
  logic [7:0]  pc_in = '0;
  logic [31:0] ir_in = '0;
  logic [31:0] alu_in = '0;
  logic        we_in = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [7:0]  rd_pc;
  logic [31:0] rd_ir;
  logic [31:0] rd_alu;
  logic        rd_we;
  logic [1:0]  state;
  logic [4:0]  level;
  logic        overflow;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  cpu_trace_buffer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .TS_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .post_count(post_count),
    .valid_in(valid_in), .pc_in(pc_in), .ir_in(ir_in), .alu_in(alu_in), .we_in(we_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ir(rd_ir),
    .rd_alu(rd_alu), .rd_we(rd_we), .state(state), .level(level), .overflow(overflow)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ir;
    logic [31:0] alu;
    logic        we;
    logic [15:0] ts;
    bit          chk_ts;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tb_cyc  = 0;

  // Bench-side edge count since reset, mirrors what a timestamp should read.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ir_of(input logic [7:0] pc);
    return {24'hA5C300, 8'h00} | {24'h0, pc};
  endfunction

  function automatic logic [31:0] alu_of(input logic [7:0] pc);
    return 32'h1000_0000 + {24'h0, pc} * 3;
  endfunction

  task automatic push_exp(input logic [7:0] pc, input bit use_ts, input logic [15:0] ts);
    exp_t e;
    e.pc = pc; e.ir = ir_of(pc); e.alu = alu_of(pc); e.we = pc[0];
    e.ts = ts; e.chk_ts = use_ts;
    exp_q.push_back(e);
  endtask

  // Monitor: every record accepted by the consumer must match the queue head.
  always @(negedge clk) begin
    if (reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {56'h0, rd_pc}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("drain_pc",  {56'h0, rd_pc},  {56'h0, e.pc});
        chk("drain_ir",  {32'h0, rd_ir},  {32'h0, e.ir});
        chk("drain_alu", {32'h0, rd_alu}, {32'h0, e.alu});
        chk("drain_we",  {63'h0, rd_we},  {63'h0, e.we});
`ifdef TRACE_TIMESTAMP_EN
        if (e.chk_ts) chk("drain_ts", {48'h0, rd_ts}, {48'h0, e.ts});
`endif
      end
    end
  end

  task automatic do_arm;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic retire(input logic [7:0] pc);
    valid_in = 1'b1; pc_in = pc; ir_in = ir_of(pc); alu_in = alu_of(pc); we_in = pc[0];
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain;
    bit done = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state == 2'b00) begin done = 1; break; end
    end
    rd_ready = 1'b0;
    chk("drain_timeout", {63'h0, done}, 64'h1);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_level", {59'h0, level}, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    // Reset state
    chk("rst_state", {62'h0, state}, 0);
    chk("rst_level", {59'h0, level}, 0);
    chk("rst_valid", {63'h0, rd_valid}, 0);
    chk("rst_ovf",   {63'h0, overflow}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: basic trigger with one post record
    do_arm();
    chk("t1_armed", {62'h0, state}, 64'h1);
    trig_pc = 8'h03; post_count = 4'd1;
    for (int p = 0; p < 4; p++) retire(8'(p));
    chk("t1_post", {62'h0, state}, 64'h2);
    retire(8'h04);
    chk("t1_done",  {62'h0, state}, 64'h3);
    chk("t1_level", {59'h0, level}, 64'd5);
    chk("t1_ovf",   {63'h0, overflow}, 0);
    for (int p = 0; p < 5; p++) push_exp(8'(p), 0, 0);
    drain();
    chk("t1_idle", {62'h0, state}, 0);

    // 2: overflow wrap, trigger with post_count 0
    do_arm();
    trig_pc = 8'hFF; post_count = 4'd0;
    for (int p = 0; p < 20; p++) retire(8'(p));
    chk("t2_armed", {62'h0, state}, 64'h1);
    chk("t2_level_full", {59'h0, level}, 64'd16);
    chk("t2_ovf", {63'h0, overflow}, 64'h1);
    retire(8'hFF);
    chk("t2_done", {62'h0, state}, 64'h3);
    chk("t2_level", {59'h0, level}, 64'd16);
    for (int p = 5; p < 20; p++) push_exp(8'(p), 0, 0);
    push_exp(8'hFF, 0, 0);
    drain();

    // 3: max post_count keeps the trigger record as the head
    do_arm();
    trig_pc = 8'h10; post_count = 4'd15;
    retire(8'h0E); retire(8'h0F); retire(8'h10);
    chk("t3_post", {62'h0, state}, 64'h2);
    for (int p = 8'h11; p <= 8'h1F; p++) retire(8'(p));
    chk("t3_done",  {62'h0, state}, 64'h3);
    chk("t3_level", {59'h0, level}, 64'd16);
    chk("t3_head",  {56'h0, rd_pc}, 64'h10);
    for (int p = 8'h10; p <= 8'h1F; p++) push_exp(8'(p), 0, 0);
    drain();

    // 4: backpressure holds the head, arm discards the buffer
    do_arm();
    trig_pc = 8'h23; post_count = 4'd0;
    for (int p = 8'h20; p <= 8'h23; p++) retire(8'(p));
    chk("t4_level", {59'h0, level}, 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_pc",    {56'h0, rd_pc}, 64'h20);
      chk("t4_hold_level", {59'h0, level}, 64'd4);
    end
    @(posedge clk); #1;
    do_arm();
    chk("t4_rearm_state", {62'h0, state}, 64'h1);
    chk("t4_rearm_level", {59'h0, level}, 0);
    chk("t4_rearm_valid", {63'h0, rd_valid}, 0);
    chk("t4_rearm_pc",    {56'h0, rd_pc}, 0);

    // 5: async reset mid-POST, then valid_in ignored in IDLE
    trig_pc = 8'h30; post_count = 4'd5;
    retire(8'h30); retire(8'h31);
    chk("t5_post", {62'h0, state}, 64'h2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_rst_state", {62'h0, state}, 0);
    chk("t5_rst_level", {59'h0, level}, 0);
    chk("t5_rst_valid", {63'h0, rd_valid}, 0);
    chk("t5_rst_rd",    {rd_pc, rd_ir, rd_we, 23'h0}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    retire(8'h30); retire(8'h33);
    chk("t5_idle_state", {62'h0, state}, 0);
    chk("t5_idle_level", {59'h0, level}, 0);
    chk("t5_idle_ovf",   {63'h0, overflow}, 0);

`ifdef TRACE_TIMESTAMP_EN
    // 6: timestamps captured at edges 12, 13, 17 after reset
    do_reset();
    while (tb_cyc < 10) begin @(posedge clk); #1; end
    do_arm();
    trig_pc = 8'h42; post_count = 4'd0;
    while (tb_cyc < 12) begin @(posedge clk); #1; end
    retire(8'h40);
    retire(8'h41);
    while (tb_cyc < 17) begin @(posedge clk); #1; end
    retire(8'h42);
    chk("t6_done", {62'h0, state}, 64'h3);
    push_exp(8'h40, 1, 16'd12);
    push_exp(8'h41, 1, 16'd13);
    push_exp(8'h42, 1, 16'd17);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
